// File: rtl/decode_stage_if.sv
// decode_stage_if: decode-stage bus (fetch instruction, writeback port in; operands, field slices, control enables out)
interface decode_stage_if;
  logic [31:0] instruction;
  logic        ren_in;
  logic [4:0]  rd_in;
  logic [31:0] data_write;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] select;
  logic        j1en;
  logic        j2en;
  logic        ren_out;
  logic        men;
  logic        ben;
  logic        exen;
  logic [4:0]  aluop;
  logic [4:0]  shamt;
  logic [4:0]  rd_out;
  logic [16:0] immediate;
  logic [26:0] target;
  modport master (
    output instruction, ren_in, rd_in, data_write,
    input  A, B, select, j1en, j2en, ren_out, men, ben, exen, aluop, shamt, rd_out, immediate, target
  );
  modport slave (
    input  instruction, ren_in, rd_in, data_write,
    output A, B, select, j1en, j2en, ren_out, men, ben, exen, aluop, shamt, rd_out, immediate, target
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: lightbike ID stage with 32x32 regfile and write bypass; ports clock, reset (sync active-low), bus (decode_stage_if.slave)
module decode_stage (
  input logic clock,
  input logic reset,
  decode_stage_if.slave bus
);
  localparam logic [4:0] OP_R    = 5'd0;
  localparam logic [4:0] OP_J    = 5'd1;
  localparam logic [4:0] OP_BNE  = 5'd2;
  localparam logic [4:0] OP_JAL  = 5'd3;
  localparam logic [4:0] OP_JR   = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_BLT  = 5'd6;
  localparam logic [4:0] OP_SW   = 5'd7;
  localparam logic [4:0] OP_LW   = 5'd8;
  localparam logic [4:0] OP_SETX = 5'd21;
  localparam logic [4:0] OP_BEX  = 5'd22;
  logic [31:0] regs [32];
  logic [4:0] op, rd, rs, rt, a_addr, b_addr;
  logic byp;
  assign op = bus.instruction[31:27];
  assign rd = bus.instruction[26:22];
  assign rs = bus.instruction[21:17];
  assign rt = bus.instruction[16:12];
  assign bus.shamt = bus.instruction[11:7];
  assign bus.aluop = bus.instruction[6:2];
  assign bus.immediate = bus.instruction[16:0];
  assign bus.target = bus.instruction[26:0];
  assign bus.select = 32'd1 << op;
  always_comb begin
    a_addr = op == OP_BEX ? 5'd30 : rs;
    b_addr = (op == OP_SW || op == OP_BNE || op == OP_BLT || op == OP_JR) ? rd : rt;
    byp = bus.ren_in && bus.rd_in != 5'd0;
    bus.A = (byp && bus.rd_in == a_addr) ? bus.data_write : a_addr == 5'd0 ? 32'd0 : regs[a_addr];
    bus.B = (byp && bus.rd_in == b_addr) ? bus.data_write : b_addr == 5'd0 ? 32'd0 : regs[b_addr];
    bus.ren_out = op == OP_R || op == OP_ADDI || op == OP_LW || op == OP_JAL || op == OP_SETX;
    bus.men = op == OP_SW;
    bus.ben = op == OP_BNE || op == OP_BLT;
    bus.j1en = op == OP_J || op == OP_JAL;
    bus.j2en = op == OP_JR;
    bus.exen = op == OP_BEX;
    bus.rd_out = op == OP_JAL ? 5'd31 : op == OP_SETX ? 5'd30 : rd;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (byp) begin
      regs[bus.rd_in] <= bus.data_write;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and table-driven check of decode_stage against a behavioural register/decode model
module tb_decode_stage;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic checking = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mem [32];
  decode_stage_if bus ();
  decode_stage dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural register state as the writeback stage sees it.
  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    end else if (bus.ren_in && bus.rd_in != 5'd0) begin
      mem[bus.rd_in] = bus.data_write;
    end
  end

  function automatic logic [31:0] model_read(input logic [4:0] addr);
    if (bus.ren_in && bus.rd_in != 5'd0 && bus.rd_in == addr) return bus.data_write;
    return addr == 5'd0 ? 32'd0 : mem[addr];
  endfunction

  always @(negedge clock) begin
    if (checking) begin
      logic [4:0] op, rd, rs, rt, pa, pb, erd;
      logic [5:0] ctl;
      op = bus.instruction[31:27];
      rd = bus.instruction[26:22];
      rs = bus.instruction[21:17];
      rt = bus.instruction[16:12];
      pa = rs;
      pb = rt;
      erd = rd;
      ctl = 6'b0;
      case (op)
        5'd0:  ctl = 6'b100000;
        5'd1:  ctl = 6'b000100;
        5'd2:  begin ctl = 6'b001000; pb = rd; end
        5'd3:  begin ctl = 6'b100100; erd = 5'd31; end
        5'd4:  begin ctl = 6'b000010; pb = rd; end
        5'd5:  ctl = 6'b100000;
        5'd6:  begin ctl = 6'b001000; pb = rd; end
        5'd7:  begin ctl = 6'b010000; pb = rd; end
        5'd8:  ctl = 6'b100000;
        5'd21: begin ctl = 6'b100000; erd = 5'd30; end
        5'd22: begin ctl = 6'b000001; pa = 5'd30; end
        default: ctl = 6'b0;
      endcase
      check("A", bus.A, model_read(pa));
      check("B", bus.B, model_read(pb));
      check("select", bus.select, 32'd2 ** op);
      check("ctl{ren,men,ben,j1,j2,ex}",
            {26'd0, bus.ren_out, bus.men, bus.ben, bus.j1en, bus.j2en, bus.exen}, {26'd0, ctl});
      check("rd_out", {27'd0, bus.rd_out}, {27'd0, erd});
      check("fields", {bus.aluop, bus.shamt, bus.immediate},
            {bus.instruction[6:2], bus.instruction[11:7], bus.instruction[16:0]});
      check("target", {5'd0, bus.target}, {5'd0, bus.instruction[26:0]});
    end
  end

  task automatic step(input logic [31:0] instr, input logic ren, input logic [4:0] rd, input logic [31:0] data);
    @(posedge clock);
    #2;
    bus.instruction = instr;
    bus.ren_in = ren;
    bus.rd_in = rd;
    bus.data_write = data;
    @(negedge clock);
    #1;
  endtask

  logic [4:0] ops [13] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd21, 5'd22, 5'd9, 5'd31};

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    bus.instruction = 32'd0;
    bus.ren_in = 1'b1;
    bus.rd_in = 5'd3;
    bus.data_write = 32'hFFFF_FFFF;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    bus.ren_in = 1'b0;
    bus.rd_in = 5'd0;
    bus.data_write = 32'd0;
    checking = 1'b1;
    @(negedge clock);
    #1;
    check("rst A", bus.A, 32'd0);
    check("rst B", bus.B, 32'd0);
    check("rst select", bus.select, 32'h0000_0001);
    check("rst en", {26'd0, bus.ren_out, bus.men, bus.ben, bus.j1en, bus.j2en, bus.exen}, 32'h20);
    step(32'h0006_0000, 1'b0, 5'd0, 32'd0);
    check("r3 cleared by reset", bus.A, 32'd0);
    step(32'd0, 1'b1, 5'd1, 32'd1);
    step(32'h0002_1000, 1'b0, 5'd0, 32'd0);
    check("r1 A", bus.A, 32'd1);
    check("r1 B", bus.B, 32'd1);
    step(32'h0002_1000, 1'b1, 5'd1, 32'd2);
    check("r1 bypass A", bus.A, 32'd2);
    step(32'h2042_0001, 1'b0, 5'd0, 32'd0);
    check("jr j2en", {31'd0, bus.j2en}, 32'd1);
    check("jr ren_out", {31'd0, bus.ren_out}, 32'd0);
    check("jr A", bus.A, 32'd2);
    check("jr B", bus.B, 32'd2);
    check("jr rd_out", {27'd0, bus.rd_out}, 32'd1);
    check("jr imm", {15'd0, bus.immediate}, 32'h1);
    step(32'd0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    check("r0 write bypass A", bus.A, 32'd0);
    step(32'd0, 1'b0, 5'd0, 32'd0);
    check("r0 A", bus.A, 32'd0);
    check("r0 B", bus.B, 32'd0);
    step(32'h000A_0000, 1'b1, 5'd5, 32'h1234);
    check("bypass r5 A", bus.A, 32'h1234);
    step(32'd0, 1'b1, 5'd30, 32'hCAFE_0030);
    step(32'h1DAB_CDEF, 1'b0, 5'd0, 32'd0);
    check("jal j1en", {31'd0, bus.j1en}, 32'd1);
    check("jal ren_out", {31'd0, bus.ren_out}, 32'd1);
    check("jal rd_out", {27'd0, bus.rd_out}, 32'd31);
    check("jal target", {5'd0, bus.target}, 32'h05AB_CDEF);
    step(32'hA800_0000, 1'b0, 5'd0, 32'd0);
    check("setx rd_out", {27'd0, bus.rd_out}, 32'd30);
    step(32'hB000_0000, 1'b0, 5'd0, 32'd0);
    check("bex exen", {31'd0, bus.exen}, 32'd1);
    check("bex A", bus.A, 32'hCAFE_0030);
    step(32'h380A_0000, 1'b0, 5'd0, 32'd0);
    check("sw men", {31'd0, bus.men}, 32'd1);
    check("sw B reads rd r0", bus.B, 32'd0);
    for (int i = 0; i < 48; i++) begin
      logic [31:0] r;
      logic [31:0] d;
      r = $urandom();
      d = $urandom();
      step({ops[$urandom_range(0, 12)], r[26:0]}, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), d);
    end
    @(posedge clock);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage of the lightbike 32-bit five-stage CPU.
- Contains the 32x32 register file, which is written by the writeback stage.
- Splits the fetched instruction into fields and reads the two source operands.
- Generates the per-instruction control enables consumed by execute, memory and PC-control logic.

Parameters:
- none (fixed 32-bit datapath, 32 registers, 5-bit opcode)

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- instruction  in  32  instruction from fetch
- ren_in  in  1  writeback register-write enable
- rd_in  in  5  writeback destination register
- data_write  in  32  writeback data
- A  out  32  operand A (register read port 1)
- B  out  32  operand B (register read port 2)
- select  out  32  one-hot opcode decode: bit[opcode]=1
- j1en  out  1  direct jump (j, jal)
- j2en  out  1  register jump (jr)
- ren_out  out  1  instruction writes a register
- men  out  1  memory write (sw)
- ben  out  1  conditional branch (bne, blt)
- exen  out  1  exception branch (bex)
- aluop  out  5  instruction[6:2]
- shamt  out  5  instruction[11:7]
- rd_out  out  5  destination register
- immediate  out  17  instruction[16:0]
- target  out  27  instruction[26:0]

Behaviour:
- Fields: op=[31:27], rd=[26:22], rs=[21:17], rt=[16:12], shamt=[11:7], aluop=[6:2], imm=[16:0], target=[26:0].
- Opcodes:
  - 00000 R-type
  - 00001 j
  - 00010 bne
  - 00011 jal
  - 00100 jr
  - 00101 addi
  - 00110 blt
  - 00111 sw
  - 01000 lw
  - 10101 setx
  - 10110 bex
- Register file: 32x32.
  - Write on rising clock edge when reset=1 and ren_in=1 and rd_in!=0.
  - r0 always reads 0; writes to r0 are ignored.
- Reset: on a rising edge with reset=0, all 32 registers clear to 0. Any write on that edge is ignored.
- Reads are combinational.
  - Port A address: rs, except bex, which reads r30.
  - Port B address: rt for R-type; rd for sw, bne, blt and jr; rt otherwise.
- Write bypass: if ren_in=1, rd_in!=0 and rd_in equals a read address, that port outputs data_write in the same cycle.
- Data written on edge N is visible on A/B after edge N (zero-cycle read latency after the write).
- Control outputs, all combinational from op; unlisted opcodes drive all enables to 0.
  - ren_out=1 for R-type, addi, lw, jal, setx.
  - men=1 for sw.
  - ben=1 for bne, blt.
  - j1en=1 for j, jal.
  - j2en=1 for jr.
  - exen=1 for bex.
- rd_out: 31 for jal, 30 for setx, otherwise rd.
- select: 32-bit one-hot, bit op set, all other bits 0.
- aluop, shamt, immediate, target: raw field slices, no extension. Sign extension is done in execute.
- Outputs have no reset value of their own; they follow instruction and register contents. After reset every register read returns 0.

Test Plan:
1. Hold reset=0 for 2 edges, then release; instruction=0 -> A=0, B=0, select=32'h00000001, ren_out=1, all other enables 0.
2. Write ren_in=1, rd_in=1, data_write=1 for one edge; then instruction[21:17]=1, [16:12]=1 -> A=1, B=1.
3. Overwrite r1 with 2; next cycle decode instruction 32'h20420001 (op 00100 jr, rd=1, rs=1) -> j2en=1, ren_out=0, A=2, B=2, rd_out=1, immediate=17'h00001.
4. Write r0 with 32'hDEADBEEF, then read r0 on both ports -> A=0, B=0.
5. ren_in=1, rd_in=5, data_write=32'h1234 while decoding add with rs=5 in the same cycle -> A=32'h1234 via bypass, before the edge.
6. Decode jal (op 00011) -> j1en=1, ren_out=1, rd_out=31, target=instruction[26:0]. Decode setx -> rd_out=30. Decode bex -> exen=1, A=r30.
